// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared types and default sizes for the register file with busy scoreboard.
//   rf_state_t : bulk-clear sequencer states (RF_IDLE, RF_CLEAR)
//   RF_DATA_W  : default register width
//   RF_ADDR_W  : default address width (DEPTH = 2**RF_ADDR_W)
package regfile_pkg;

  localparam int RF_DATA_W = 16;
  localparam int RF_ADDR_W = 4;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   One busy bit per register. A bit is set when an instruction that will
//   produce that register issues, and cleared when its result is written back.
// Ports
//   clk, rst            clock, asynchronous active-high reset (all bits 0)
//   set_en, set_idx     mark set_idx busy (issue)
//   clr_en, clr_idx     mark clr_idx not busy (writeback)
//   wipe_en, wipe_idx   clear one bit as part of the sequenced bulk clear
//   rd_idx_n/rd_busy_n  two combinational read taps (n = 1, 2)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_idx,
  input  logic              wipe_en,
  input  logic [ADDR_W-1:0] wipe_idx,
  input  logic [ADDR_W-1:0] rd_idx_1,
  output logic              rd_busy_1,
  input  logic [ADDR_W-1:0] rd_idx_2,
  output logic              rd_busy_2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;

  // The set is written after the clear so that an issue and a writeback to
  // the same index on the same edge leave the bit set: the newer producer
  // is still outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (wipe_en) begin
      busy[wipe_idx] <= 1'b0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

  assign rd_busy_1 = busy[rd_idx_1];
  assign rd_busy_2 = busy[rd_idx_2];

endmodule

// File: rtl/register_file_sb.sv
// register_file_sb
//   Parametrised register file with two combinational read ports, one
//   writeback port, an issue port feeding a busy scoreboard, and a sequenced
//   bulk clear that zeroes one register (and its busy bit) per cycle.
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   reg_write_en/dest/data   writeback strobe, index, data
//   reg_read_addr_n          read index, port n (n = 1, 2)
//   reg_read_data_n          read data, port n (combinational)
//   reg_read_busy_n          scoreboard bit of reg_read_addr_n (combinational)
//   issue_en, issue_dest     mark issue_dest busy
//   clr_req                  start the bulk clear
//   clr_busy                 high while the bulk clear runs
// Build option
//   REGFILE_BYPASS_EN : forward same-cycle writeback data to the read ports.
//
// state    | meaning
// RF_IDLE  | normal operation, writes and issues accepted
// RF_CLEAR | zeroing mem[clr_cnt]/busy[clr_cnt], writes/issues/clr_req ignored
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write_en,
  input  logic [ADDR_W-1:0] reg_write_dest,
  input  logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] reg_read_addr_1,
  output logic [DATA_W-1:0] reg_read_data_1,
  output logic              reg_read_busy_1,
  input  logic [ADDR_W-1:0] reg_read_addr_2,
  output logic [DATA_W-1:0] reg_read_data_2,
  output logic              reg_read_busy_2,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int                DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic              HAS_ZERO = (ZERO_REG != 0);

  rf_state_t         state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              idle;
  logic              wr_ok, issue_ok;
  logic              sb_busy_1, sb_busy_2;

  assign idle     = (state == RF_IDLE);
  assign clr_busy = (state == RF_CLEAR);
  assign wr_ok    = idle && reg_write_en && !(HAS_ZERO && reg_write_dest == '0);
  assign issue_ok = idle && issue_en && !(HAS_ZERO && issue_dest == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      RF_IDLE:  if (clr_req) state_nxt = RF_CLEAR;
      RF_CLEAR: if (clr_cnt == LAST) state_nxt = RF_IDLE;
      default:  state_nxt = RF_IDLE;
    endcase
  end

  // clr_cnt wraps from LAST back to 0 on the final clear edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RF_IDLE;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == RF_CLEAR) clr_cnt <= clr_cnt + 1'b1;
      else                   clr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == RF_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_ok) begin
      mem[reg_write_dest] <= reg_write_data;
    end
  end

  regfile_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_ok),
    .set_idx  (issue_dest),
    .clr_en   (wr_ok),
    .clr_idx  (reg_write_dest),
    .wipe_en  (clr_busy),
    .wipe_idx (clr_cnt),
    .rd_idx_1 (reg_read_addr_1),
    .rd_busy_1(sb_busy_1),
    .rd_idx_2 (reg_read_addr_2),
    .rd_busy_2(sb_busy_2)
  );

  always_comb begin
    reg_read_data_1 = mem[reg_read_addr_1];
    reg_read_busy_1 = sb_busy_1;
    reg_read_data_2 = mem[reg_read_addr_2];
    reg_read_busy_2 = sb_busy_2;
`ifdef REGFILE_BYPASS_EN
    // wr_ok already excludes CLEAR and the hardwired zero register.
    if (wr_ok && reg_read_addr_1 == reg_write_dest) begin
      reg_read_data_1 = reg_write_data;
      reg_read_busy_1 = issue_ok && (issue_dest == reg_write_dest);
    end
    if (wr_ok && reg_read_addr_2 == reg_write_dest) begin
      reg_read_data_2 = reg_write_data;
      reg_read_busy_2 = issue_ok && (issue_dest == reg_write_dest);
    end
`endif
    if (HAS_ZERO && reg_read_addr_1 == '0) begin
      reg_read_data_1 = '0;
      reg_read_busy_1 = 1'b0;
    end
    if (HAS_ZERO && reg_read_addr_2 == '0) begin
      reg_read_data_2 = '0;
      reg_read_busy_2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
// tb_register_file_sb
//   Directed bench for register_file_sb (16x16, ZERO_REG=1). The driver
//   queues expected read-port values tagged with the cycle they apply to;
//   a monitor on the falling edge pops and compares them.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_en;
  logic [3:0]  reg_write_dest;
  logic [15:0] reg_write_data;
  logic [3:0]  reg_read_addr_1;
  logic [15:0] reg_read_data_1;
  logic        reg_read_busy_1;
  logic [3:0]  reg_read_addr_2;
  logic [15:0] reg_read_data_2;
  logic        reg_read_busy_2;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        clr_req;
  logic        clr_busy;

  register_file_sb dut (
    .clk            (clk),
    .rst            (rst),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .reg_read_addr_1(reg_read_addr_1),
    .reg_read_data_1(reg_read_data_1),
    .reg_read_busy_1(reg_read_busy_1),
    .reg_read_addr_2(reg_read_addr_2),
    .reg_read_data_2(reg_read_data_2),
    .reg_read_busy_2(reg_read_busy_2),
    .issue_en       (issue_en),
    .issue_dest     (issue_dest),
    .clr_req        (clr_req),
    .clr_busy       (clr_busy)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_DATA1 = 0, K_BUSY1 = 1, K_DATA2 = 2, K_BUSY2 = 3, K_CLRB = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_DATA1: return "read_data_1";
      K_BUSY1: return "read_busy_1";
      K_DATA2: return "read_data_2";
      K_BUSY2: return "read_busy_2";
      default: return "clr_busy";
    endcase
  endfunction

  function automatic logic [15:0] actual(input int k);
    case (k)
      K_DATA1: return reg_read_data_1;
      K_BUSY1: return {15'b0, reg_read_busy_1};
      K_DATA2: return reg_read_data_2;
      K_BUSY2: return {15'b0, reg_read_busy_2};
      default: return {15'b0, clr_busy};
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [15:0] a;
      e = q.pop_front();
      n_vec++;
      if (e.cyc < cyc) begin
        n_err++;
        $display("FAIL %s cycle %0d: check not sampled in its cycle (now %0d)", kname(e.kind), e.cyc, cyc);
      end else begin
        a = actual(e.kind);
        if (a !== e.val) begin
          n_err++;
          $display("FAIL %s cycle %0d: got %h expected %h", kname(e.kind), cyc, a, e.val);
        end
      end
    end
  end

  task automatic expect_v(input int kind, input logic [15:0] v);
    q.push_back('{cyc, kind, v});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    reg_write_en = 1'b0;
    issue_en     = 1'b0;
    clr_req      = 1'b0;
  endtask

  task automatic write_reg(input logic [3:0] d, input logic [15:0] v);
    reg_write_en   = 1'b1;
    reg_write_dest = d;
    reg_write_data = v;
    step();
    quiet();
  endtask

  task automatic check_all_zero();
    for (int a = 0; a < 16; a++) begin
      reg_read_addr_1 = 4'(a);
      reg_read_addr_2 = 4'(15 - a);
      expect_v(K_DATA1, 16'h0);
      expect_v(K_BUSY1, 16'h0);
      expect_v(K_DATA2, 16'h0);
      expect_v(K_BUSY2, 16'h0);
      expect_v(K_CLRB, 16'h0);
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    reg_write_dest = '0;
    reg_write_data = '0;
    reg_read_addr_1 = '0;
    reg_read_addr_2 = '0;
    issue_dest = '0;
    quiet();
    repeat (3) step();
    rst = 1'b0;

    // Reset state
    check_all_zero();

    // Write r5 = BEEF, visible next cycle (same cycle only with bypass)
    reg_read_addr_1 = 4'd5;
    reg_write_en = 1'b1; reg_write_dest = 4'd5; reg_write_data = 16'hBEEF;
    expect_v(K_DATA1, BYP ? 16'hBEEF : 16'h0000);
    step(); quiet();
    expect_v(K_DATA1, 16'hBEEF);
    expect_v(K_BUSY1, 16'h0);
    step();

    // Write to r0 is dropped
    reg_read_addr_2 = 4'd0;
    reg_write_en = 1'b1; reg_write_dest = 4'd0; reg_write_data = 16'h1234;
    expect_v(K_DATA2, 16'h0);
    step(); quiet();
    expect_v(K_DATA2, 16'h0);
    step();

    // Issue r7 -> busy; writeback clears it
    reg_read_addr_1 = 4'd7;
    issue_en = 1'b1; issue_dest = 4'd7;
    expect_v(K_BUSY1, 16'h0);
    step(); quiet();
    expect_v(K_BUSY1, 16'h1);
    reg_write_en = 1'b1; reg_write_dest = 4'd7; reg_write_data = 16'h00AA;
    expect_v(K_BUSY1, BYP ? 16'h0 : 16'h1);
    expect_v(K_DATA1, BYP ? 16'h00AA : 16'h0000);
    step(); quiet();
    expect_v(K_BUSY1, 16'h0);
    expect_v(K_DATA1, 16'h00AA);

    // Same-edge issue and write to r7: data lands, busy stays set
    reg_write_en = 1'b1; reg_write_dest = 4'd7; reg_write_data = 16'h0055;
    issue_en = 1'b1; issue_dest = 4'd7;
    step(); quiet();
    expect_v(K_BUSY1, 16'h1);
    expect_v(K_DATA1, 16'h0055);

    // Issue to r0 is ignored
    reg_read_addr_2 = 4'd0;
    issue_en = 1'b1; issue_dest = 4'd0;
    step(); quiet();
    expect_v(K_BUSY2, 16'h0);
    step();

    // Bypass case: write r3, read port 2 in the same cycle
    reg_read_addr_2 = 4'd3;
    reg_write_en = 1'b1; reg_write_dest = 4'd3; reg_write_data = 16'h5A5A;
    expect_v(K_DATA2, BYP ? 16'h5A5A : 16'h0000);
    expect_v(K_BUSY2, 16'h0);
    step(); quiet();
    expect_v(K_DATA2, 16'h5A5A);
    step();

    // Fill r1..r15, leave r9 busy, then bulk clear
    for (int i = 1; i < 16; i++) write_reg(4'(i), 16'h1000 + 16'(i));
    issue_en = 1'b1; issue_dest = 4'd9;
    step(); quiet();
    reg_read_addr_1 = 4'd9;
    expect_v(K_BUSY1, 16'h1);
    expect_v(K_DATA1, 16'h1009);
    clr_req = 1'b1;
    expect_v(K_CLRB, 16'h0);
    step(); quiet();
    for (int k = 0; k < 16; k++) begin
      // Writes/issues/clr_req attempted throughout the clear must be dropped
      reg_write_en = 1'b1; reg_write_dest = 4'd15; reg_write_data = 16'hFFFF;
      issue_en = 1'b1; issue_dest = 4'd15;
      clr_req = (k == 3);
      reg_read_addr_1 = 4'd15;
      reg_read_addr_2 = 4'(k);
      expect_v(K_CLRB, 16'h1);
      expect_v(K_DATA1, 16'h100F);
      expect_v(K_DATA2, (k == 0) ? 16'h0 : 16'h1000 + 16'(k));
      step();
    end
    quiet();
    check_all_zero();

    // Reset in the middle of a clear
    write_reg(4'd12, 16'hCCCC);
    clr_req = 1'b1;
    step(); quiet();
    for (int k = 0; k < 6; k++) begin
      expect_v(K_CLRB, 16'h1);
      step();
    end
    reg_read_addr_1 = 4'd12;
    rst = 1'b1;
    #1;
    expect_v(K_CLRB, 16'h0);
    expect_v(K_DATA1, 16'h0);
    step();
    rst = 1'b0;
    check_all_zero();

    repeat (3) step();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d checks never sampled, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
